// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state type, geometry helpers and address-field extraction for cache_wb
package cache_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITEBACK,
      S_REFILL,
      S_FLUSH_SCAN,
      S_FLUSH_WB
   } cache_state_t;

   function automatic int off_w(input int words);
      return (words > 1) ? $clog2(words) : 0;
   endfunction

   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int tag_w(input int addr_w, input int lines, input int words);
      return addr_w - idx_w(lines) - off_w(words) - 2;
   endfunction

   function automatic logic [63:0] addr_word(input logic [63:0] addr, input int words);
      return (addr >> 2) & 64'(words - 1);
   endfunction

   function automatic logic [63:0] addr_index(input logic [63:0] addr, input int lines,
                                              input int words);
      return (addr >> (2 + off_w(words))) & 64'(lines - 1);
   endfunction

   function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int lines,
                                            input int words);
      return addr >> (2 + off_w(words) + idx_w(lines));
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// rtl/cache_line_store.sv - line data/tag arrays with valid and dirty bits
module cache_line_store #(
   parameter int LINES  = 256,
   parameter int WORDS  = 4,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 20,
   parameter int IDX_W  = 8,
   parameter int CNT_W  = 2,
   parameter int OFF_W  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic [CNT_W-1:0]  rd_word,
   output logic [DATA_W-1:0] rd_data,
   output logic [TAG_W-1:0]  rd_tag,
   output logic              rd_valid,
   output logic              rd_dirty,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [CNT_W-1:0]  wr_word,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              fill_en,
   input  logic [TAG_W-1:0]  fill_tag,
   input  logic              dirty_set,
   input  logic              dirty_clr
);

   localparam int DA_W = $clog2(LINES * WORDS);

   logic [DATA_W-1:0] data_q [LINES*WORDS];
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [LINES-1:0]  valid_q;
   logic [LINES-1:0]  dirty_q;
   logic [DA_W-1:0]   rd_addr;
   logic [DA_W-1:0]   wr_addr;

   assign rd_addr  = (DA_W'(rd_idx) << OFF_W) | DA_W'(rd_word);
   assign wr_addr  = (DA_W'(wr_idx) << OFF_W) | DA_W'(wr_word);
   assign rd_data  = data_q[rd_addr];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_valid = valid_q[rd_idx];
   assign rd_dirty = dirty_q[rd_idx];

   // Payload arrays carry no reset; valid/dirty gate every use of them.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_q[wr_addr] <= wr_data;
      end
      if (fill_en) begin
         tag_q[wr_idx] <= fill_tag;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (fill_en) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= 1'b0;
         end
         if (dirty_set) begin
            dirty_q[wr_idx] <= 1'b1;
         end
         if (dirty_clr) begin
            dirty_q[wr_idx] <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cache_wb.sv
// rtl/cache_wb.sv - direct-mapped write-back write-allocate data cache with flush
module cache_wb
   import cache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LINES  = 256,
   parameter int WORDS  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   input  logic              flush_req,
   output logic              flush_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam int OFF_W = off_w(WORDS);
   localparam int IDX_W = idx_w(LINES);
   localparam int TAG_W = tag_w(ADDR_W, LINES, WORDS);
   localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINES - 1);

   cache_state_t      state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [TAG_W-1:0]  tag_q, tag_d;

   logic [IDX_W-1:0]  cpu_idx;
   logic [TAG_W-1:0]  cpu_tag;
   logic [CNT_W-1:0]  cpu_word;

   logic [IDX_W-1:0]  rd_idx;
   logic [CNT_W-1:0]  rd_word;
   logic [DATA_W-1:0] rd_data;
   logic [TAG_W-1:0]  rd_tag;
   logic              rd_valid;
   logic              rd_dirty;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [CNT_W-1:0]  wr_word;
   logic [DATA_W-1:0] wr_data;
   logic              fill_en;
   logic              dirty_set;
   logic              dirty_clr;

   assign cpu_word = CNT_W'(addr_word(64'(cpu_addr), WORDS));
   assign cpu_idx  = IDX_W'(addr_index(64'(cpu_addr), LINES, WORDS));
   assign cpu_tag  = TAG_W'(addr_tag(64'(cpu_addr), LINES, WORDS));

   function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx,
                                                   input logic [CNT_W-1:0] word);
      return (ADDR_W'(tag) << (IDX_W + OFF_W + 2)) | (ADDR_W'(idx) << (OFF_W + 2)) |
             (ADDR_W'(word) << 2);
   endfunction

   cache_line_store #(
      .LINES  (LINES),
      .WORDS  (WORDS),
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .IDX_W  (IDX_W),
      .CNT_W  (CNT_W),
      .OFF_W  (OFF_W)
   ) u_store (
      .clk       (clk),
      .reset     (reset),
      .rd_idx    (rd_idx),
      .rd_word   (rd_word),
      .rd_data   (rd_data),
      .rd_tag    (rd_tag),
      .rd_valid  (rd_valid),
      .rd_dirty  (rd_dirty),
      .wr_en     (wr_en),
      .wr_idx    (wr_idx),
      .wr_word   (wr_word),
      .wr_data   (wr_data),
      .fill_en   (fill_en),
      .fill_tag  (tag_q),
      .dirty_set (dirty_set),
      .dirty_clr (dirty_clr)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         tag_q   <= tag_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      tag_d      = tag_q;
      rd_idx     = idx_q;
      rd_word    = cnt_q;
      wr_en      = 1'b0;
      wr_idx     = idx_q;
      wr_word    = cnt_q;
      wr_data    = mem_rdata;
      fill_en    = 1'b0;
      dirty_set  = 1'b0;
      dirty_clr  = 1'b0;
      cpu_ready  = 1'b0;
      cpu_rdata  = '0;
      flush_done = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;

      unique case (state_q)
         S_IDLE: begin
            rd_idx  = cpu_idx;
            rd_word = cpu_word;
            if (cpu_req) begin
               if (rd_valid && rd_tag == cpu_tag) begin
                  cpu_ready = 1'b1;
                  if (cpu_we) begin
                     wr_en     = 1'b1;
                     wr_idx    = cpu_idx;
                     wr_word   = cpu_word;
                     wr_data   = cpu_wdata;
                     dirty_set = 1'b1;
                  end else begin
                     cpu_rdata = rd_data;
                  end
               end else begin
                  idx_d   = cpu_idx;
                  tag_d   = cpu_tag;
                  cnt_d   = '0;
                  state_d = (rd_valid && rd_dirty) ? S_WRITEBACK : S_REFILL;
               end
            end else if (flush_req) begin
               idx_d   = '0;
               cnt_d   = '0;
               state_d = S_FLUSH_SCAN;
            end
         end

         // The victim tag is still in the array until the refill completes.
         S_WRITEBACK, S_FLUSH_WB: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = line_addr(rd_tag, idx_q, cnt_q);
            mem_wdata = rd_data;
            if (mem_ready) begin
               if (cnt_q == LAST_WORD) begin
                  cnt_d     = '0;
                  dirty_clr = 1'b1;
                  state_d   = (state_q == S_WRITEBACK) ? S_REFILL : S_FLUSH_SCAN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         S_REFILL: begin
            mem_req  = 1'b1;
            mem_addr = line_addr(tag_q, idx_q, cnt_q);
            if (mem_ready) begin
               wr_en = 1'b1;
               if (cnt_q == LAST_WORD) begin
                  cnt_d   = '0;
                  fill_en = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         S_FLUSH_SCAN: begin
            if (rd_valid && rd_dirty) begin
               cnt_d   = '0;
               state_d = S_FLUSH_WB;
            end else if (idx_q == LAST_IDX) begin
               flush_done = 1'b1;
               idx_d      = '0;
               state_d    = S_IDLE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_wb.sv
// tb/tb_cache_wb.sv - scoreboard bench for cache_wb against a flat-memory reference model
module tb_cache_wb;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } xfer_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        flush_req = 1'b0;
   logic        flush_done;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;

   always #5 clk = ~clk;

   cache_wb #(.ADDR_W(32), .DATA_W(32), .LINES(256), .WORDS(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_ready  (cpu_ready),
      .flush_req  (flush_req),
      .flush_done (flush_done),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   int total = 0;
   int bad = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int fd_cnt = 0;
   int mem_wait = 0;

   xfer_t       exp_mem[$];
   logic [31:0] exp_rd[$];
   logic [31:0] amem[int];
   logic [31:0] bmem[int];
   bit          m_valid[256];
   bit          m_dirty[256];
   int          m_tag[256];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] dflt(input int wa);
      logic [31:0] w;
      w = wa;
      return (w * 32'h9E37_79B9) ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [31:0] aget(input int wa);
      if (amem.exists(wa)) return amem[wa];
      return dflt(wa);
   endfunction

   function automatic logic [31:0] bget(input int wa);
      if (bmem.exists(wa)) return bmem[wa];
      return dflt(wa);
   endfunction

   function automatic logic [31:0] laddr(input int tag, input int idx, input int w);
      return (32'(tag) << 12) | (32'(idx) << 4) | (32'(w) << 2);
   endfunction

   // Reference: a flat architectural memory plus per-index tag/valid/dirty bookkeeping.
   task automatic model_access(input bit we, input logic [31:0] a, input logic [31:0] d,
                               output int waits);
      int    idx;
      int    tag;
      xfer_t x;
      idx   = int'((a >> 4) & 32'hFF);
      tag   = int'(a >> 12);
      waits = 0;
      if (!(m_valid[idx] && m_tag[idx] == tag)) begin
         waits = 1;
         if (m_valid[idx] && m_dirty[idx]) begin
            for (int w = 0; w < 4; w++) begin
               x.we   = 1'b1;
               x.addr = laddr(m_tag[idx], idx, w);
               x.data = aget(int'(x.addr >> 2));
               exp_mem.push_back(x);
               waits += 3;
            end
         end
         for (int w = 0; w < 4; w++) begin
            x.we   = 1'b0;
            x.addr = laddr(tag, idx, w);
            x.data = '0;
            exp_mem.push_back(x);
            waits += 3;
         end
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tag;
         m_dirty[idx] = 1'b0;
      end
      if (we) begin
         amem[int'(a >> 2)] = d;
         m_dirty[idx] = 1'b1;
      end else begin
         exp_rd.push_back(aget(int'(a >> 2)));
      end
   endtask

   task automatic model_flush(output int nwr);
      xfer_t x;
      nwr = 0;
      for (int i = 0; i < 256; i++) begin
         if (m_valid[i] && m_dirty[i]) begin
            for (int w = 0; w < 4; w++) begin
               x.we   = 1'b1;
               x.addr = laddr(m_tag[i], i, w);
               x.data = aget(int'(x.addr >> 2));
               exp_mem.push_back(x);
               nwr++;
            end
            m_dirty[i] = 1'b0;
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      amem = bmem;
      exp_mem.delete();
      exp_rd.delete();
   endtask

   // Memory with two wait cycles per transfer; checks each transfer against the scoreboard.
   initial begin
      xfer_t x;
      forever begin
         @(negedge clk);
         if (mem_ready) begin
            mem_ready = 1'b0;
            mem_wait  = 0;
         end
         if (reset && mem_req) begin
            if (mem_wait == 2) begin
               mem_ready = 1'b1;
               if (exp_mem.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL mem_unexpected: got=%0h expected=none", mem_addr);
               end else begin
                  x = exp_mem.pop_front();
                  check("mem_we", 64'(mem_we), 64'(x.we));
                  check("mem_addr", 64'(mem_addr), 64'(x.addr));
                  if (x.we) check("mem_wdata", 64'(mem_wdata), 64'(x.data));
               end
               if (mem_we) begin
                  bmem[int'(mem_addr >> 2)] = mem_wdata;
                  wr_cnt++;
               end else begin
                  mem_rdata = bget(int'(mem_addr >> 2));
                  rd_cnt++;
               end
            end else begin
               mem_wait++;
            end
         end else begin
            mem_wait = 0;
         end
      end
   end

   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (flush_done) fd_cnt++;
         if (reset && cpu_req && cpu_ready && !cpu_we) begin
            if (exp_rd.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rd_unexpected: got=%0h expected=none", cpu_rdata);
            end else begin
               e = exp_rd.pop_front();
               check("cpu_rdata", 64'(cpu_rdata), 64'(e));
            end
         end
      end
   end

   task automatic do_access(input bit we, input logic [31:0] a, input logic [31:0] d);
      int expw;
      int waited;
      model_access(we, a, d, expw);
      @(posedge clk);
      #1;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = d;
      waited    = 0;
      forever begin
         @(negedge clk);
         if (cpu_ready || waited > 100) break;
         waited++;
      end
      check("access_latency", 64'(waited), 64'(expw));
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
   endtask

   task automatic do_flush(input int exp_writes);
      int nwr;
      int w0;
      int f0;
      int waited;
      model_flush(nwr);
      w0 = wr_cnt;
      f0 = fd_cnt;
      @(posedge clk);
      #1;
      flush_req = 1'b1;
      @(posedge clk);
      #1;
      flush_req = 1'b0;
      waited = 0;
      while (fd_cnt == f0 && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      @(negedge clk);
      check("flush_done_pulses", 64'(fd_cnt - f0), 64'd1);
      check("flush_writes_model", 64'(wr_cnt - w0), 64'(nwr));
      if (exp_writes >= 0) check("flush_writes", 64'(wr_cnt - w0), 64'(exp_writes));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   int idx_pick[4] = '{0, 1, 2, 255};

   initial begin
      logic [31:0] a;
      int          r0;
      int          waited;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_cpu_ready", 64'(cpu_ready), 64'd0);
      check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
      check("rst_flush_done", 64'(flush_done), 64'd0);
      check("rst_mem_req", 64'(mem_req), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      do_access(1'b0, 32'h0000_1004, '0);
      do_access(1'b0, 32'h0000_1008, '0);
      do_access(1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
      do_access(1'b0, 32'h0000_1004, '0);
      do_access(1'b0, 32'h0000_2004, '0);
      do_access(1'b1, 32'h0000_3008, 32'h1234_5678);
      do_access(1'b0, 32'h0000_3008, '0);
      do_access(1'b1, 32'h0000_0FF4, 32'hCAFE_0001);
      do_flush(8);
      do_flush(0);

      model_access(1'b0, 32'h0000_5004, '0, r0);
      r0 = rd_cnt;
      @(posedge clk);
      #1;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h0000_5004;
      waited   = 0;
      while (rd_cnt < r0 + 2 && waited < 100) begin
         @(posedge clk);
         waited++;
      end
      check("refill_progress", 64'(rd_cnt - r0), 64'd2);
      @(negedge clk);
      #1;
      reset   = 1'b0;
      cpu_req = 1'b0;
      #1;
      check("reset_mem_req_drop", 64'(mem_req), 64'd0);
      check("reset_valid_clear", 64'(dut.u_store.valid_q != '0), 64'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      do_access(1'b0, 32'h0000_5004, '0);

      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 24) == 0) begin
            do_flush(-1);
         end else begin
            a = (32'($urandom_range(0, 3)) << 12) | (32'(idx_pick[$urandom_range(0, 3)]) << 4) |
                (32'($urandom_range(0, 3)) << 2);
            do_access(1'($urandom_range(0, 1)), a, $urandom);
         end
      end
      do_flush(-1);

      repeat (4) @(negedge clk);
      check("exp_mem_drained", 64'(exp_mem.size()), 64'd0);
      check("exp_rd_drained", 64'(exp_rd.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
